// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB requester bridge of the timer subsystem:
// default bus widths, watchdog default, FSM state encoding and the timer
// register map (TDR/TCR/TSR).
package apb_master_bridge_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  // Timer register slave address map
  localparam logic [7:0] ADDR_TDR = 8'h00;
  localparam logic [7:0] ADDR_TCR = 8'h01;
  localparam logic [7:0] ADDR_TSR = 8'h02;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Counter width able to hold 0..t-1 (at least one bit).
  function automatic int wdog_cnt_w(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundle of the bridge's command, response and APB signals.
//   master : bridge side (accepts commands, drives APB, returns responses)
//   slave  : environment side (sequencer + APB completer)
// Command: cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata
// Response: rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout
// APB: psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr
interface apb_master_bridge_if
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_master_bridge_wdog.sv
// Wait-state watchdog for the APB ACCESS phase.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : restart count at 0 (asserted the cycle before ACCESS)
//   inc_i      : count one wait cycle (ACCESS with pready low)
//   expired_o  : count has reached TIMEOUT_CYCLES-1; never set when
//                TIMEOUT_CYCLES is 0
module apb_wait_watchdog
  import apb_master_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CNT_W = wdog_cnt_w(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at all-ones so a long stall never wraps back to a low count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_en
      assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_dis
      assign expired_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester bridge: single-beat commands in, SETUP/ACCESS transfers
// out, one response per command with read data, error and timeout flags.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : command / response / APB signals (master modport)
// All APB and response outputs come straight from registers; cmd_ready is
// a decode of the state register (high only in IDLE).
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_master_bridge_if.master  bus
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic wd_expired;

  // Counter restarts during SETUP so it reads 0 on the first ACCESS cycle.
  apb_wait_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == SETUP),
    .inc_i     ((state_q == ACCESS) && !bus.pready),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // pready beats the watchdog when both land on the same cycle.
        if (bus.pready) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
        end else if (wd_expired) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases followed by
// random transfers, each checked against a transaction-level model of the
// expected APB phase lengths and response payload.
module tb_apb_master_bridge;
  import apb_master_bridge_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full command. waits = number of ACCESS cycles the completer holds
  // pready low before raising it; rdly = cycles rsp_ready stays low;
  // rst_mid = pulse reset on the second ACCESS cycle instead of completing.
  task automatic do_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdv, input bit serr, input int waits,
                         input int rdly, input bit rst_mid);
    bit         to;
    int         n_exp;
    int         acc;
    logic [7:0] exp_rd;
    bit         exp_err;

    // Reference: completion on ACCESS cycle index `waits` unless the
    // watchdog has already run TO cycles.
    to     = (waits >= TO);
    n_exp  = to ? TO : waits + 1;
    exp_rd = (to || wr) ? 8'h00 : rdv;
    exp_err = to ? 1'b1 : serr;

    @(negedge clk);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_psel", bus.psel, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;

    @(negedge clk);
    // Garbage on the command side must be ignored outside IDLE.
    bus.cmd_valid = 1'($urandom);
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = 8'($urandom);
    bus.pready    = 1'($urandom);   // ignored during SETUP
    bus.prdata    = 8'($urandom);
    bus.pslverr   = 1'($urandom);
    chk("setup_psel", bus.psel, 1);
    chk("setup_penable", bus.penable, 0);
    chk("setup_paddr", bus.paddr, addr);
    chk("setup_pwrite", bus.pwrite, wr);
    chk("setup_pwdata", bus.pwdata, wdata);
    chk("setup_cmd_ready", bus.cmd_ready, 0);

    acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!(bus.psel && bus.penable)) break;
      chk("access_paddr", bus.paddr, addr);
      chk("access_pwdata", bus.pwdata, wdata);
      chk("access_pwrite", bus.pwrite, wr);
      if (rst_mid && acc == 1) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'b0;
        return;
      end
      if (acc == waits) begin
        bus.pready  = 1'b1;
        bus.prdata  = rdv;
        bus.pslverr = serr;
      end else begin
        bus.pready  = 1'b0;
        bus.prdata  = 8'($urandom);
        bus.pslverr = 1'($urandom);
      end
      acc++;
    end
    bus.pready = 1'b0;

    chk("access_cycles", acc, n_exp);
    chk("resp_psel", bus.psel, 0);
    chk("resp_penable", bus.penable, 0);
    chk("resp_valid", bus.rsp_valid, 1);
    chk("resp_rdata", bus.rsp_rdata, exp_rd);
    chk("resp_err", bus.rsp_err, exp_err);
    chk("resp_timeout", bus.rsp_timeout, to);
    chk("resp_cmd_ready", bus.cmd_ready, 0);

    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'($urandom);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_err", bus.rsp_err, exp_err);
      chk("hold_timeout", bus.rsp_timeout, to);
      chk("hold_psel", bus.psel, 0);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
    end

    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("done_rsp_valid", bus.rsp_valid, 0);
    chk("done_rsp_err", bus.rsp_err, 0);
    chk("done_cmd_ready", bus.cmd_ready, 1);
    chk("done_psel", bus.psel, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_psel", bus.psel, 0);
    chk("reset_penable", bus.penable, 0);
    chk("reset_pwrite", bus.pwrite, 0);
    chk("reset_paddr", bus.paddr, 0);
    chk("reset_pwdata", bus.pwdata, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_timeout", bus.rsp_timeout, 0);
    rst = 1'b0;

    // Directed
    do_xfer(1'b1, ADDR_TCR, 8'hA5, 8'h5C, 1'b0, 1,    0, 1'b0); // write, 1 wait
    do_xfer(1'b0, ADDR_TSR, 8'h00, 8'h01, 1'b0, 0,    0, 1'b0); // read, no wait
    do_xfer(1'b0, 8'h05,    8'h00, 8'h77, 1'b1, 0,    0, 1'b0); // slave error
    do_xfer(1'b0, ADDR_TDR, 8'h00, 8'h33, 1'b0, 1000, 0, 1'b0); // stuck -> timeout
    do_xfer(1'b0, ADDR_TDR, 8'h00, 8'h44, 1'b0, TO,   0, 1'b0); // just past limit
    do_xfer(1'b0, ADDR_TDR, 8'h00, 8'h9E, 1'b0, TO-1, 0, 1'b0); // pready on last cycle wins
    do_xfer(1'b1, ADDR_TDR, 8'h3C, 8'h00, 1'b1, TO-1, 0, 1'b0); // write err on last cycle
    do_xfer(1'b0, ADDR_TSR, 8'h00, 8'hC3, 1'b0, 2,    5, 1'b0); // rsp backpressure
    do_xfer(1'b0, ADDR_TCR, 8'h00, 8'h12, 1'b0, 3,    0, 1'b1); // reset mid ACCESS
    do_xfer(1'b1, ADDR_TCR, 8'h5A, 8'h00, 1'b0, 0,    1, 1'b0); // recovers after reset

    // Random
    for (int n = 0; n < 60; n++) begin
      do_xfer(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, TO + 4)),
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
